// File: rtl/tb_irq_inj_pkg.sv
// Shared types and constants for the e203 interrupt stimulus injector.
package tb_irq_inj_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ASSERT = 2'd2,
    ST_DONE   = 2'd3
  } chan_state_e;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED_MIX  = 32'h9E37_79B9;

  function automatic logic [31:0] chan_seed(input logic [31:0] base, input int unsigned idx);
    logic [31:0] s;
    s = base ^ (32'(idx + 1) * SEED_MIX);
    return (s == '0) ? SEED_MIX : s;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/tb_irq_inj_chan.sv
// One interrupt channel: random delay, assert until handler ack PC commits, re-arm.
// Optional assertion timeout under TB_IRQ_INJ_TIMEOUT_EN.
module tb_irq_inj_chan
  import tb_irq_inj_pkg::*;
#(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned DLY_W   = 10,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 4096,
  parameter logic [31:0] SEED    = 32'h0000_0001
) (
  input  logic             hfclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             stop,
  input  logic             cmt_valid,
  input  logic [PC_W-1:0]  cmt_pc,
  input  logic [PC_W-1:0]  ack_pc,
  input  logic [DLY_W-1:0] max_dly,
  output logic             irq,
  output logic [CNT_W-1:0] cnt,
  output logic             tmo_err,
  output logic             in_done
);

  chan_state_e      state, state_nxt;
  logic [31:0]      lfsr;
  logic [DLY_W-1:0] dly_cnt, dly_nxt, dly_range, dly_load;
  logic             stop_seen, stop_eff, ack, tmo_hit, load;

  assign dly_range = (max_dly == '0) ? DLY_W'(1) : max_dly;
  assign dly_load  = DLY_W'(1) + (lfsr[DLY_W-1:0] % dly_range);
  // stop is sticky so a short pulse still parks the channel after its current assertion
  assign stop_eff  = stop | stop_seen;
  assign ack       = (state == ST_ASSERT) && cmt_valid && (cmt_pc == ack_pc);
  assign irq       = (state == ST_ASSERT);
  assign in_done   = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    load      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (stop_eff) state_nxt = ST_DONE;
        else if (enable) begin
          state_nxt = ST_WAIT;
          load      = 1'b1;
        end
      end
      ST_WAIT: begin
        if (stop_eff) state_nxt = ST_DONE;
        else if (dly_cnt == DLY_W'(1)) state_nxt = ST_ASSERT;
        else dly_nxt = dly_cnt - DLY_W'(1);
      end
      ST_ASSERT: begin
        if (ack || tmo_hit) begin
          if (stop_eff) state_nxt = ST_DONE;
          else begin
            state_nxt = ST_WAIT;
            load      = 1'b1;
          end
        end
      end
      ST_DONE: state_nxt = ST_DONE;
    endcase
    if (load) dly_nxt = dly_load;
  end

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lfsr      <= SEED;
      dly_cnt   <= '0;
      cnt       <= '0;
      stop_seen <= 1'b0;
    end else begin
      state   <= state_nxt;
      dly_cnt <= dly_nxt;
      if (load) lfsr <= lfsr_step(lfsr);
      if (stop) stop_seen <= 1'b1;
      if (ack && (cnt != '1)) cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef TB_IRQ_INJ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state == ST_ASSERT) && !ack && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      if ((state == ST_ASSERT) && (state_nxt == ST_ASSERT)) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else tmo_cnt <= '0;
      if (tmo_hit) tmo_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

endmodule

// File: rtl/tb_irq_injector.sv
// Multi-channel interrupt stimulus generator for the e203 simulation top.
// Define TB_IRQ_INJ_TIMEOUT_EN to enable per-channel assertion timeouts.
module tb_irq_injector
  import tb_irq_inj_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 3,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned DLY_W   = 10,
  parameter int unsigned CNT_W   = 16,
  parameter logic [31:0] SEED    = 32'hACE1_0001,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                     hfclk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     stop,
  input  logic                     cmt_valid,
  input  logic [PC_W-1:0]          cmt_pc,
  input  logic [NUM_IRQ*PC_W-1:0]  ack_pc,
  input  logic [DLY_W-1:0]         max_dly,
  output logic [NUM_IRQ-1:0]       irq_o,
  output logic [NUM_IRQ*CNT_W-1:0] irq_cnt,
  output logic [NUM_IRQ-1:0]       timeout_err,
  output logic                     busy,
  output logic                     done
);

  logic [NUM_IRQ-1:0] chan_done;

  for (genvar k = 0; k < NUM_IRQ; k++) begin : g_chan
    tb_irq_inj_chan #(
      .PC_W    (PC_W),
      .DLY_W   (DLY_W),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT),
      .SEED    (chan_seed(SEED, k))
    ) u_chan (
      .hfclk     (hfclk),
      .rst_n     (rst_n),
      .enable    (enable),
      .stop      (stop),
      .cmt_valid (cmt_valid),
      .cmt_pc    (cmt_pc),
      .ack_pc    (ack_pc[k*PC_W +: PC_W]),
      .max_dly   (max_dly),
      .irq       (irq_o[k]),
      .cnt       (irq_cnt[k*CNT_W +: CNT_W]),
      .tmo_err   (timeout_err[k]),
      .in_done   (chan_done[k])
    );
  end

  assign busy = |irq_o;

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= &chan_done;
  end

endmodule

// File: tb/tb_tb_irq_injector.sv
// Directed self-checking bench for tb_irq_injector: delays, acks, stop, reset,
// saturation (CNT_W=2 instance) and timeout (TIMEOUT=16 instance).
module tb_tb_irq_injector;

  localparam logic [31:0] PC0 = 32'h8000_0100;
  localparam logic [31:0] PC1 = 32'h8000_0200;
  localparam logic [31:0] PC2 = 32'h8000_0300;
  localparam logic [31:0] PCS = 32'h8000_00A6;
  localparam logic [31:0] PC_SAT = 32'h8000_0050;
  localparam logic [31:0] PC_TMO = 32'h8000_0070;

  logic        hfclk;
  logic        rst_n, enable, enable_tmo, stop, cmt_valid;
  logic [31:0] cmt_pc;
  logic [95:0] ack_pc;
  logic [9:0]  max_dly, max_dly2;

  logic [2:0]  irq_o, timeout_err;
  logic [47:0] irq_cnt;
  logic        busy, done;

  logic        irq_sat, tmo_sat, busy_sat, done_sat;
  logic [1:0]  cnt_sat;
  logic        irq_tmo, tmo_tmo, busy_tmo, done_tmo;
  logic [15:0] cnt_tmo;

  int unsigned n_vec = 0;
  int unsigned n_miss = 0;

  initial hfclk = 1'b0;
  always #5 hfclk = ~hfclk;

  tb_irq_injector dut (
    .hfclk(hfclk), .rst_n(rst_n), .enable(enable), .stop(stop),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .ack_pc(ack_pc), .max_dly(max_dly),
    .irq_o(irq_o), .irq_cnt(irq_cnt), .timeout_err(timeout_err),
    .busy(busy), .done(done)
  );

  tb_irq_injector #(.NUM_IRQ(1), .CNT_W(2), .SEED(32'h1234_5678)) dut_sat (
    .hfclk(hfclk), .rst_n(rst_n), .enable(enable), .stop(stop),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .ack_pc(PC_SAT), .max_dly(max_dly2),
    .irq_o(irq_sat), .irq_cnt(cnt_sat), .timeout_err(tmo_sat),
    .busy(busy_sat), .done(done_sat)
  );

  tb_irq_injector #(.NUM_IRQ(1), .TIMEOUT(16)) dut_tmo (
    .hfclk(hfclk), .rst_n(rst_n), .enable(enable_tmo), .stop(stop),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .ack_pc(PC_TMO), .max_dly(max_dly2),
    .irq_o(irq_tmo), .irq_cnt(cnt_tmo), .timeout_err(tmo_tmo),
    .busy(busy_tmo), .done(done_tmo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hfclk);
    #1;
  endtask

  // edges counted from the current slot until each line is first seen high
  task automatic measure_rises(input int limit, output int r0, output int r1,
                               output int r2, output int rs);
    r0 = 0; r1 = 0; r2 = 0; rs = 0;
    for (int n = 1; n <= limit; n++) begin
      step();
      if (irq_o[0] && r0 == 0) r0 = n;
      if (irq_o[1] && r1 == 0) r1 = n;
      if (irq_o[2] && r2 == 0) r2 = n;
      if (irq_sat && rs == 0) rs = n;
      if (r0 != 0 && r1 != 0 && r2 != 0 && rs != 0) break;
    end
  endtask

  task automatic commit(input logic [31:0] pc);
    cmt_valid = 1'b1;
    cmt_pc    = pc;
    step();
    cmt_valid = 1'b0;
    cmt_pc    = '0;
  endtask

  initial begin
    int r0, r1, r2, rs, h;
    rst_n = 1'b0; enable = 1'b0; enable_tmo = 1'b0; stop = 1'b0;
    cmt_valid = 1'b0; cmt_pc = '0; ack_pc = {PC2, PC1, PC0};
    max_dly = 10'd1000; max_dly2 = 10'd1000;

    #12;
    check("rst_irq", 64'(irq_o), 64'h0);
    check("rst_cnt", 64'(irq_cnt), 64'h0);
    check("rst_tmo", 64'(timeout_err), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);

    @(posedge hfclk); #1;
    rst_n = 1'b1;
    repeat (5) step();
    check("no_irq_before_enable", 64'(irq_o), 64'h0);

    // first delays: 1 + (seed[9:0] % 1000) per channel seed
    enable = 1'b1;
    measure_rises(1000, r0, r1, r2, rs);
    check("dly0_first", 64'(r0 - 1), 64'd441);
    check("dly1_first", 64'(r1 - 1), 64'd884);
    check("dly2_first", 64'(r2 - 1), 64'd299);
    check("dly_other_seed", 64'(rs - 1), 64'd962);
    check("busy_asserted", 64'(busy), 64'h1);

    ack_pc = {PCS, PCS, PCS};
    commit(PCS);
    check("shared_ack_irq", 64'(irq_o), 64'h0);
    check("shared_ack_cnt", 64'(irq_cnt), {16'h0, 16'd1, 16'd1, 16'd1});
    check("shared_ack_sat_untouched", 64'(cnt_sat), 64'h0);

    measure_rises(700, r0, r1, r2, rs);
    check("dly0_second", 64'(r0), 64'd221);
    check("dly1_second", 64'(r1), 64'd443);
    check("dly2_second", 64'(r2), 64'd662);

    // asynchronous reset in the middle of an assertion
    rst_n = 1'b0;
    #1;
    check("async_rst_irq", 64'(irq_o), 64'h0);
    check("async_rst_cnt", 64'(irq_cnt), 64'h0);
    check("async_rst_sat_irq", 64'(irq_sat), 64'h0);
    @(posedge hfclk); #1;
    rst_n = 1'b1;
    measure_rises(1000, r0, r1, r2, rs);
    check("repro_dly0", 64'(r0 - 1), 64'd441);
    check("repro_dly1", 64'(r1 - 1), 64'd884);
    check("repro_dly2", 64'(r2 - 1), 64'd299);
    check("repro_dly_sat", 64'(rs - 1), 64'd962);

    max_dly = '0;
    commit(PCS);
    check("dly0_ack_irq", 64'(irq_o), 64'h0);
    check("dly0_ack_cnt", 64'(irq_cnt), {16'h0, 16'd1, 16'd1, 16'd1});
    step();
    check("dly0_min_gap", 64'(irq_o), 64'h7);

    // saturation on the CNT_W=2 instance
    max_dly2 = 10'd1;
    for (int i = 1; i <= 5; i++) begin
      for (int w = 0; w < 10 && !irq_sat; w++) step();
      check("sat_irq_high", 64'(irq_sat), 64'h1);
      commit(PC_SAT);
      if (i == 1) check("sat_cnt_1", 64'(cnt_sat), 64'd1);
      if (i == 3) check("sat_cnt_3", 64'(cnt_sat), 64'd3);
    end
    check("sat_cnt_5", 64'(cnt_sat), 64'd3);

    // channel 0: ack on the third cycle of each assertion, ten rounds
    ack_pc = {PC2, PC1, PC0};
    commit(PC0);
    for (int round = 0; round < 10; round++) begin
      for (int w = 0; w < 10 && !irq_o[0]; w++) step();
      check("round_rise", 64'(irq_o[0]), 64'h1);
      h = 1;
      while (h < 8) begin
        if (h == 3) begin
          cmt_valid = 1'b1;
          cmt_pc    = PC0;
        end
        step();
        cmt_valid = 1'b0;
        if (!irq_o[0]) break;
        h++;
      end
      check("round_high_cycles", 64'(h), 64'd3);
    end
    check("round_cnt", 64'(irq_cnt[15:0]), 64'd12);

    // timeout instance
    enable_tmo = 1'b1;
    for (int w = 0; w < 10 && !irq_tmo; w++) step();
    check("tmo_rise", 64'(irq_tmo), 64'h1);
    h = 1;
    while (h < 40) begin
      step();
      if (!irq_tmo) break;
      h++;
    end
`ifdef TB_IRQ_INJ_TIMEOUT_EN
    check("tmo_high_cycles", 64'(h), 64'd16);
    check("tmo_err_set", 64'(tmo_tmo), 64'h1);
    check("tmo_cnt_unchanged", 64'(cnt_tmo), 64'h0);
    repeat (5) step();
    check("tmo_err_sticky", 64'(tmo_tmo), 64'h1);
`else
    check("tmo_holds", 64'(h), 64'd40);
    check("tmo_err_tied", 64'(tmo_tmo), 64'h0);
`endif

    // stop: channel 0 in WAIT, channels 1 and 2 in ASSERT
    max_dly = 10'd1000;
    commit(PC0);
    stop = 1'b1;
    check("stop_pre_irq", 64'(irq_o), 64'h6);
    step();
    stop = 1'b0;
    check("stop_irq", 64'(irq_o), 64'h6);
    check("stop_done_low", 64'(done), 64'h0);
    repeat (20) step();
    check("stop_ch0_quiet", 64'(irq_o), 64'h6);
    commit(PC1);
    check("stop_ch1_ack_irq", 64'(irq_o), 64'h4);
    check("stop_ch1_cnt", 64'(irq_cnt[31:16]), 64'd2);
    repeat (3) step();
    check("stop_ch1_no_rearm", 64'(irq_o), 64'h4);
    commit(PC2);
    check("stop_all_irq", 64'(irq_o), 64'h0);
    check("stop_ch2_cnt", 64'(irq_cnt[47:32]), 64'd2);
    check("done_not_yet", 64'(done), 64'h0);
    step();
    check("done_lag", 64'(done), 64'h1);
    commit(PC0);
    check("ack_outside_assert", 64'(irq_cnt[15:0]), 64'd13);
    check("final_tmo_main", 64'(timeout_err), 64'h0);
    check("final_busy", 64'(busy), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
